// File: rtl/id_decode_unit.sv
// ID-stage block for the RV32I pipeline: field extraction, main control decode,
// immediate generation, and the 32x32 integer register file with WB write-through.
module id_decode_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic        funct7_5,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm,
    output logic [2:0]  imm_sel,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        branch,
    output logic        jump,
    output logic        alu_src,
    output logic        illegal,
    output logic [1:0]  alu_op
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [2:0] ImmI = 3'd0;
    localparam logic [2:0] ImmS = 3'd1;
    localparam logic [2:0] ImmB = 3'd2;
    localparam logic [2:0] ImmU = 3'd3;
    localparam logic [2:0] ImmJ = 3'd4;

    logic [XLEN-1:0] regs_q [NREGS];

    logic [6:0]  opcode;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    // {reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_src}
    logic [6:0]  dec_ctrl;
    logic [1:0]  dec_alu_op;
    logic [2:0]  dec_imm_sel;
    logic        dec_bad;

    assign opcode   = instr[6:0];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7_5 = instr[30];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Register array: reset clears everything and wins over a same-cycle write; x0 never written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we && (wb_addr != 5'd0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Read ports: x0 is always zero, otherwise a pending WB write to the same index bypasses the array.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != 5'd0) begin
            rs1_data = (wb_we && (wb_addr == rs1)) ? wb_data : regs_q[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_data = (wb_we && (wb_addr == rs2)) ? wb_data : regs_q[rs2];
        end
    end

    // Main control decode by opcode, with per-opcode funct3/funct7 legality checks.
    always_comb begin
        dec_ctrl    = 7'b0000000;
        dec_alu_op  = 2'b00;
        dec_imm_sel = ImmI;
        dec_bad     = 1'b0;
        case (opcode)
            OpR: begin
                dec_ctrl   = 7'b1000000;
                dec_alu_op = 2'b10;
                // Only SUB and SRA use funct7[5]
                dec_bad    = funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101);
            end
            OpImm: begin
                dec_ctrl   = 7'b1000001;
                dec_alu_op = 2'b11;
            end
            OpLoad: begin
                dec_ctrl = 7'b1101001;
                dec_bad  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OpStore: begin
                dec_ctrl    = 7'b0010001;
                dec_imm_sel = ImmS;
                dec_bad     = (funct3 >= 3'b011);
            end
            OpBranch: begin
                dec_ctrl    = 7'b0000100;
                dec_alu_op  = 2'b01;
                dec_imm_sel = ImmB;
                dec_bad     = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OpLui, OpAuipc: begin
                dec_ctrl    = 7'b1000001;
                dec_imm_sel = ImmU;
            end
            OpJal: begin
                dec_ctrl    = 7'b1000010;
                dec_imm_sel = ImmJ;
            end
            OpJalr: begin
                dec_ctrl = 7'b1000011;
                dec_bad  = (funct3 != 3'b000);
            end
            default: begin
                dec_bad = 1'b1;
            end
        endcase
    end

    // Illegal instructions (including the all-zero bubble) drive every control output to zero.
    always_comb begin
        illegal = dec_bad;
        {reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_src} = 7'b0000000;
        alu_op  = 2'b00;
        imm_sel = ImmI;
        if (!dec_bad) begin
            {reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_src} = dec_ctrl;
            alu_op  = dec_alu_op;
            imm_sel = dec_imm_sel;
        end
    end

    // Immediate select; unused selector codes yield zero.
    always_comb begin
        imm = '0;
        case (imm_sel)
            ImmI:    imm = imm_i;
            ImmS:    imm = imm_s;
            ImmB:    imm = imm_b;
            ImmU:    imm = imm_u;
            ImmJ:    imm = imm_j;
            default: imm = '0;
        endcase
    end

endmodule

// File: tb/tb_id_decode_unit.sv
// Scoreboard bench for id_decode_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_id_decode_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;

    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [2:0]  imm_sel;
    logic        reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_src, illegal;
    logic [1:0]  alu_op;

    always #5 clk = ~clk;

    id_decode_unit dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm        (imm),
        .imm_sel    (imm_sel),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .branch     (branch),
        .jump       (jump),
        .alu_src    (alu_src),
        .illegal    (illegal),
        .alu_op     (alu_op)
    );

    typedef struct {
        int          id;
        bit          chk_dec;
        logic [12:0] ctrl;
        logic [31:0] imm;
        logic [18:0] fields;
        bit          chk_data;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic [12:0] act_ctrl;
    logic [18:0] act_fields;
    assign act_ctrl = {reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_src,
                       alu_op, imm_sel, illegal};
    assign act_fields = {rs1, rs2, rd, funct3, funct7_5};

    function automatic logic [18:0] fl(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] d, input logic [2:0] f3,
                                       input logic f7);
        return {a, b, d, f3, f7};
    endfunction

    function automatic exp_t xd(input int id, input logic [12:0] c, input logic [31:0] im,
                                input logic [18:0] f);
        exp_t e;
        e.id = id; e.chk_dec = 1'b1; e.ctrl = c; e.imm = im; e.fields = f;
        e.chk_data = 1'b0; e.d1 = '0; e.d2 = '0;
        return e;
    endfunction

    function automatic exp_t xr(input int id, input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        e.id = id; e.chk_dec = 1'b0; e.ctrl = '0; e.imm = '0; e.fields = '0;
        e.chk_data = 1'b1; e.d1 = d1; e.d2 = d2;
        return e;
    endfunction

    function automatic exp_t xn(input int id);
        exp_t e;
        e.id = id; e.chk_dec = 1'b0; e.ctrl = '0; e.imm = '0; e.fields = '0;
        e.chk_data = 1'b0; e.d1 = '0; e.d2 = '0;
        return e;
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] a, input logic [4:0] b);
        return {7'd0, b, a, 3'd0, 5'd0, 7'b0110011};
    endfunction

    task automatic drive(input logic rst, input logic [31:0] ins, input logic we,
                         input logic [4:0] a, input logic [31:0] d, input exp_t e);
        @(posedge clk);
        #1;
        reset   = rst;
        instr   = ins;
        wb_we   = we;
        wb_addr = a;
        wb_data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so each vector is checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk_dec) begin
                checks++;
                if (act_ctrl !== mon_e.ctrl) begin
                    errors++;
                    $display("FAIL vec%0d ctrl: got %b expected %b", mon_e.id, act_ctrl,
                             mon_e.ctrl);
                end
                checks++;
                if (imm !== mon_e.imm) begin
                    errors++;
                    $display("FAIL vec%0d imm: got %h expected %h", mon_e.id, imm, mon_e.imm);
                end
                checks++;
                if (act_fields !== mon_e.fields) begin
                    errors++;
                    $display("FAIL vec%0d fields: got %h expected %h", mon_e.id, act_fields,
                             mon_e.fields);
                end
            end
            if (mon_e.chk_data) begin
                checks++;
                if (rs1_data !== mon_e.d1) begin
                    errors++;
                    $display("FAIL vec%0d rs1_data: got %h expected %h", mon_e.id, rs1_data,
                             mon_e.d1);
                end
                checks++;
                if (rs2_data !== mon_e.d2) begin
                    errors++;
                    $display("FAIL vec%0d rs2_data: got %h expected %h", mon_e.id, rs2_data,
                             mon_e.d2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] a;
        // Reset pulse, then every index reads zero
        drive(1'b1, 32'h0, 1'b0, 5'd0, 32'h0, xn(0));
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, xn(0));
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            drive(1'b1, mk_r(a, ~a), 1'b0, 5'd0, 32'h0, xr(i, 32'h0, 32'h0));
        end
        // Write during reset is lost
        drive(1'b0, mk_r(5'd5, 5'd0), 1'b1, 5'd5, 32'hAAAA5555, xn(39));
        drive(1'b1, mk_r(5'd5, 5'd5), 1'b0, 5'd0, 32'h0, xr(40, 32'h0, 32'h0));
        // Write-through on rs1, then persistence
        drive(1'b1, mk_r(5'd3, 5'd0), 1'b1, 5'd3, 32'hDEADBEEF, xr(41, 32'hDEADBEEF, 32'h0));
        drive(1'b1, mk_r(5'd3, 5'd0), 1'b0, 5'd0, 32'h0, xr(42, 32'hDEADBEEF, 32'h0));
        // Write-through on rs2
        drive(1'b1, mk_r(5'd3, 5'd7), 1'b1, 5'd7, 32'h0BADF00D,
              xr(43, 32'hDEADBEEF, 32'h0BADF00D));
        drive(1'b1, mk_r(5'd7, 5'd3), 1'b0, 5'd0, 32'h0, xr(44, 32'h0BADF00D, 32'hDEADBEEF));
        // x0 ignores writes and bypass
        drive(1'b1, mk_r(5'd0, 5'd0), 1'b1, 5'd0, 32'h12345678, xr(45, 32'h0, 32'h0));
        drive(1'b1, mk_r(5'd0, 5'd0), 1'b0, 5'd0, 32'h0, xr(46, 32'h0, 32'h0));
        // Write to an unrelated index does not bypass
        drive(1'b1, mk_r(5'd3, 5'd7), 1'b1, 5'd9, 32'h11111111,
              xr(47, 32'hDEADBEEF, 32'h0BADF00D));
        drive(1'b1, mk_r(5'd9, 5'd0), 1'b0, 5'd0, 32'h0, xr(48, 32'h11111111, 32'h0));

        // Decode vectors: ctrl = {rw,mr,mw,m2r,br,j,src, alu_op, imm_sel, illegal}
        drive(1'b1, 32'hFFF00093, 1'b0, 5'd0, 32'h0,
              xd(50, 13'b1000001_11_000_0, 32'hFFFFFFFF, fl(5'd0, 5'd31, 5'd1, 3'd0, 1'b1)));
        drive(1'b1, 32'h0020A423, 1'b0, 5'd0, 32'h0,
              xd(51, 13'b0010001_00_001_0, 32'h00000008, fl(5'd1, 5'd2, 5'd8, 3'd2, 1'b0)));
        drive(1'b1, 32'hFE000EE3, 1'b0, 5'd0, 32'h0,
              xd(52, 13'b0000100_01_010_0, 32'hFFFFFFFC, fl(5'd0, 5'd0, 5'd29, 3'd0, 1'b1)));
        drive(1'b1, 32'h123452B7, 1'b0, 5'd0, 32'h0,
              xd(53, 13'b1000001_00_011_0, 32'h12345000, fl(5'd8, 5'd3, 5'd5, 3'd5, 1'b0)));
        drive(1'b1, 32'h001000EF, 1'b0, 5'd0, 32'h0,
              xd(54, 13'b1000010_00_100_0, 32'h00000800, fl(5'd0, 5'd1, 5'd1, 3'd0, 1'b0)));
        drive(1'b1, 32'h0000007F, 1'b0, 5'd0, 32'h0,
              xd(55, 13'b0000000_00_000_1, 32'h00000000, fl(5'd0, 5'd0, 5'd0, 3'd0, 1'b0)));
        drive(1'b1, 32'h00000000, 1'b0, 5'd0, 32'h0,
              xd(56, 13'b0000000_00_000_1, 32'h00000000, fl(5'd0, 5'd0, 5'd0, 3'd0, 1'b0)));
        drive(1'b1, 32'h00007003, 1'b0, 5'd0, 32'h0,
              xd(57, 13'b0000000_00_000_1, 32'h00000000, fl(5'd0, 5'd0, 5'd0, 3'd7, 1'b0)));
        drive(1'b1, 32'h40000033, 1'b0, 5'd0, 32'h0,
              xd(58, 13'b1000000_10_000_0, 32'h00000400, fl(5'd0, 5'd0, 5'd0, 3'd0, 1'b1)));
        drive(1'b1, 32'h40001033, 1'b0, 5'd0, 32'h0,
              xd(59, 13'b0000000_00_000_1, 32'h00000400, fl(5'd0, 5'd0, 5'd0, 3'd1, 1'b1)));
        drive(1'b1, 32'h0040A103, 1'b0, 5'd0, 32'h0,
              xd(60, 13'b1101001_00_000_0, 32'h00000004, fl(5'd1, 5'd4, 5'd2, 3'd2, 1'b0)));
        drive(1'b1, 32'h000080E7, 1'b0, 5'd0, 32'h0,
              xd(61, 13'b1000011_00_000_0, 32'h00000000, fl(5'd1, 5'd0, 5'd1, 3'd0, 1'b0)));
        drive(1'b1, 32'h00001067, 1'b0, 5'd0, 32'h0,
              xd(62, 13'b0000000_00_000_1, 32'h00000000, fl(5'd0, 5'd0, 5'd0, 3'd1, 1'b0)));
        drive(1'b1, 32'h00002063, 1'b0, 5'd0, 32'h0,
              xd(63, 13'b0000000_00_000_1, 32'h00000000, fl(5'd0, 5'd0, 5'd0, 3'd2, 1'b0)));
        drive(1'b1, 32'h00003023, 1'b0, 5'd0, 32'h0,
              xd(64, 13'b0000000_00_000_1, 32'h00000000, fl(5'd0, 5'd0, 5'd0, 3'd3, 1'b0)));
        drive(1'b1, 32'hFFFFF017, 1'b0, 5'd0, 32'h0,
              xd(65, 13'b1000001_00_011_0, 32'hFFFFF000, fl(5'd31, 5'd31, 5'd0, 3'd7, 1'b1)));

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
